raw_frame_sequencer: RTL
========================

Name: raw_frame_sequencer

Overview:
- Sequences the Bayer-raw-to-grayscale 2x2 filter: gates its shift enable from the camera pixel stream, clears its line buffer at frame start, and tracks row/column position.
- Qualifies filter output only where a full 2x2 Bayer quad has been shifted in, giving a (WIDTH/2)x(HEIGHT/2) grayscale stream with coordinates.
- Sits between camera capture and the filter, and drives the downstream grayscale consumer.

Parameters:
- WIDTH, 640, raw pixels per line; even, matches filter line-buffer depth.
- HEIGHT, 480, raw lines per frame; even.
- XW, 10, width of raw column counter (clog2(WIDTH)).
- YW, 9, width of raw row counter (clog2(HEIGHT)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; frame starts are accepted only while high.
- sof  in  1  start-of-frame pulse from capture; precedes the first pixel by at least 1 cycle.
- pixel_valid  in  1  raw pixel present on the filter's raw input this cycle.
- out_ready  in  1  downstream can take a grayscale pixel.
- clr_status  in  1  clears the sticky flags.
- filt_enable  out  1  filter shift enable (combinational).
- filt_clear  out  1  filter synchronous buffer clear (combinational).
- out_valid  out  1  filter grayscale output is a valid decimated pixel.
- out_x  out  XW-1  output column, 0..WIDTH/2-1.
- out_y  out  YW-1  output row, 0..HEIGHT/2-1.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- busy  out  1  high in ACTIVE.
- overflow  out  1  sticky: out_valid was high while out_ready was low.
- frame_err  out  1  sticky: sof arrived mid-frame.
- frame_count  out  16  completed frames; wraps at 65535 to 0.

Behaviour:
- Reset (async): state=IDLE, col=0, row=0. out_valid, out_x, out_y, frame_done, overflow, frame_err and frame_count all go to 0.
- States:
  - IDLE: sof&&run -> ACTIVE.
  - ACTIVE: last pixel accepted -> DONE; sof -> ACTIVE (restart).
  - DONE: single cycle -> IDLE, or -> ACTIVE if sof&&run in that cycle.
- filt_clear = sof && run && (state!=ACTIVE || restart). On that cycle col and row load 0 and pixel_valid is ignored.
- filt_enable = pixel_valid && state==ACTIVE && !filt_clear. An accepted pixel is exactly a cycle with filt_enable high.
- Counters on accept: col wraps WIDTH-1 -> 0 and increments row. Last pixel = row==HEIGHT-1 && col==WIDTH-1.
- out_valid is registered, high the cycle after accepting a pixel with row[0]==1 && col[0]==1. That is the cycle the filter's registered buffer holds the completed quad.
- out_x=col>>1 and out_y=row>>1 are registered with out_valid and hold their value when out_valid is low.
- No backpressure to the camera. If out_valid && !out_ready, overflow is set and the pixel is lost.
- frame_done is high in DONE, coincident with the final out_valid. frame_count increments on the same edge that enters DONE.
- sof while ACTIVE: frame_err set, counters reset via restart, filt_clear pulses, and frame_count is not incremented.
- run dropped while ACTIVE: the current frame completes; only new sof is blocked.
- clr_status clears overflow and frame_err. A simultaneous set event wins.
- pixel_valid in IDLE or DONE: ignored, with filt_enable=0.
- Mid-operation reset: immediate return to IDLE. The filter buffer is left as-is and is cleared by the next frame's filt_clear.

Decomposition:
- Shared package raw_pipe_pkg holds:
  - state enum seq_state_t {IDLE, ACTIVE, DONE};
  - default WIDTH/HEIGHT constants, shared with the filter's line-buffer depth.
- One sub-module, raw_pos_counter: col/row counter with accept, clear and last-pixel flag. Everything else stays in raw_frame_sequencer.

Test Plan:
- Nominal (WIDTH=8, HEIGHT=4, pixel_valid continuous after sof, out_ready=1) -> out_valid appears 8 times at (0,0)..(3,1) in raster order. First out_valid is 1 cycle after the pixel at row1/col1 (the 10th pixel accepted). frame_done=1 with final out_valid; frame_count=1; overflow=0.
- Gapped stream (pixel_valid toggling every cycle) -> filt_enable mirrors pixel_valid; same 8 outputs; counters frozen during gaps.
- sof after 13 pixels -> frame_err=1, filt_clear pulse, counters restart. Full frame then completes with frame_count=1.
- out_ready=0 during the 3rd output -> overflow=1 and stays set. clr_status then clears it; clr_status coincident with a new stall leaves it 1.
- run=0 with sof -> no filt_clear, busy=0, pixels ignored. run=1 plus sof in the DONE cycle -> immediate second frame, frame_count=2.
- Async reset asserted mid-frame, between clock edges -> all outputs 0 immediately, state IDLE. The next sof restarts cleanly.

Source files
------------

// File: rtl/raw_pipe_pkg.sv
// Shared definitions for the raw Bayer pipeline: sequencer states and the
// default frame geometry, which also sizes the filter's line buffer.
package raw_pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned DEF_XW     = 10;
  localparam int unsigned DEF_YW     = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  // A quad is complete once its bottom-right (odd row, odd column) pixel is in.
  function automatic logic quad_complete(input logic col_lsb, input logic row_lsb);
    return col_lsb & row_lsb;
  endfunction

endpackage

// File: rtl/raw_pos_counter.sv
// Raw column/row position of the next pixel to be accepted, with a flag for
// the last pixel of the frame.
module raw_pos_counter
  import raw_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned XW     = DEF_XW,
  parameter int unsigned YW     = DEF_YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          accept_i,
  output logic [XW-1:0] col_o,
  output logic [YW-1:0] row_o,
  output logic          last_o
);

  localparam logic [XW-1:0] COL_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] ROW_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic          col_wrap;

  assign col_wrap = (col_q == COL_MAX);
  assign last_o   = col_wrap && (row_q == ROW_MAX);
  assign col_o    = col_q;
  assign row_o    = row_q;

  // Clear has priority; the row also wraps after the last pixel of a frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (accept_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : YW'(row_q + YW'(1));
      end else begin
        col_d = XW'(col_q + XW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/raw_frame_sequencer.sv
// Frame sequencer for the Bayer-raw-to-grayscale 2x2 filter: gates the shift
// enable, clears the line buffer at frame start and qualifies decimated output.
module raw_frame_sequencer
  import raw_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned XW     = DEF_XW,
  parameter int unsigned YW     = DEF_YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          sof,
  input  logic          pixel_valid,
  input  logic          out_ready,
  input  logic          clr_status,
  output logic          filt_enable,
  output logic          filt_clear,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done,
  output logic          busy,
  output logic          overflow,
  output logic          frame_err,
  output logic [15:0]   frame_count
);

  seq_state_t    state_q;
  logic          out_valid_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;
  logic          frame_done_q;
  logic          overflow_q;
  logic          frame_err_q;
  logic [15:0]   frame_count_q;

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          last_pix;
  logic          restart;
  logic          last_accept;

  // Any accepted sof starts a frame; in ACTIVE it is a restart.
  assign filt_clear  = sof && run;
  assign restart     = filt_clear && (state_q == ACTIVE);
  assign filt_enable = pixel_valid && (state_q == ACTIVE) && !filt_clear;
  assign last_accept = filt_enable && last_pix;

  raw_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (filt_clear),
    .accept_i (filt_enable),
    .col_o    (col),
    .row_o    (row),
    .last_o   (last_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (filt_clear) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (last_accept) begin
            state_q       <= DONE;
            frame_done_q  <= 1'b1;
            frame_count_q <= 16'(frame_count_q + 16'd1);
          end
        end
        DONE: begin
          state_q <= filt_clear ? ACTIVE : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // The filter's buffer holds a finished quad one cycle after its last pixel.
      if (filt_enable && quad_complete(col[0], row[0])) begin
        out_valid_q <= 1'b1;
        out_x_q     <= XW'(col >> 1);
        out_y_q     <= YW'(row >> 1);
      end

      // Sticky flags: a set event in the same cycle beats clr_status.
      if (out_valid_q && !out_ready) begin
        overflow_q <= 1'b1;
      end else if (clr_status) begin
        overflow_q <= 1'b0;
      end

      if (restart) begin
        frame_err_q <= 1'b1;
      end else if (clr_status) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q == ACTIVE);
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule
